// File: rtl/fuzzy_seq_ctrl_if.sv
// Coprocessor core handshake: init/start levels out, done pulse and G result in.
// master = sequencer side, slave = coprocessor core side.
interface fuzzy_seq_ctrl_if;
   logic       cop_start;
   logic       cop_init;
   logic       cop_valid;
   logic [7:0] cop_g;

   modport master (
      output cop_start,
      output cop_init,
      input  cop_valid,
      input  cop_g
   );

   modport slave (
      input  cop_start,
      input  cop_init,
      output cop_valid,
      output cop_g
   );
endinterface

// File: rtl/fuzzy_seq_ctrl.sv
// Periodic sequencer for the fuzzy-logic coprocessor: paces init/start pulses,
// supervises completion with a timeout and queues results in a small FIFO.
// Ports: clk, rst_n (async low); enable/reinit/period control; cop (master
// modport: cop_start, cop_init, cop_valid, cop_g); res_data/res_seq/res_avail/
// res_pop/fifo_cnt result FIFO; busy; sticky ovf_err/tmo_err cleared by clr_err.
// Build option: define FUZZY_SEQ_TAG_EN to store and expose the 8-bit seq tag.
module fuzzy_seq_ctrl #(
   parameter int PERIOD_W   = 16,
   parameter int TMO_CYC    = 15,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          enable,
   input  logic                          reinit,
   input  logic [PERIOD_W-1:0]           period,
   fuzzy_seq_ctrl_if.master              cop,
   output logic [7:0]                    res_data,
   output logic [7:0]                    res_seq,
   output logic                          res_avail,
   input  logic                          res_pop,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt,
   output logic                          busy,
   output logic                          ovf_err,
   output logic                          tmo_err,
   input  logic                          clr_err
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int TMO_W = $clog2(TMO_CYC);
`ifdef FUZZY_SEQ_TAG_EN
   localparam int EW = 16;
`else
   localparam int EW = 8;
`endif

   typedef enum logic [2:0] {
      S_IDLE,
      S_INIT,
      S_ARM,
      S_WAIT,
      S_GAP
   } state_t;

   state_t              state, state_n;
   logic                pend_init;
   logic [PERIOD_W-1:0] pcnt;
   logic [PERIOD_W-1:0] p_load;
   logic [TMO_W-1:0]    tmo_cnt;
   logic                tmo_hit;
   logic                gap_done;

   logic [EW-1:0]       mem [FIFO_DEPTH];
   logic [PTR_W-1:0]    wr_ptr, rd_ptr;
   logic [CNT_W-1:0]    cnt;
   logic [EW-1:0]       wdata;
   logic [EW-1:0]       head;
   logic                full, empty;
   logic                push_req, do_push, do_pop, drop;

   // Periods below 2 are stretched to 2.
   assign p_load = (period < PERIOD_W'(2)) ? PERIOD_W'(1)
                                           : period - PERIOD_W'(1);

   // Counter reaches zero this cycle, so the next state can be the start.
   assign gap_done = (pcnt <= PERIOD_W'(1));

   // tmo_cnt is cleared in ARM, so in WAIT it holds (cycles since rise - 1).
   assign tmo_hit = (state == S_WAIT) && !cop.cop_valid &&
                    (tmo_cnt == TMO_W'(TMO_CYC - 1));

   always_comb begin
      state_n = state;
      unique case (state)
         S_IDLE: begin
            if (enable)
               state_n = pend_init ? S_INIT : S_ARM;
         end
         S_INIT: state_n = S_ARM;
         S_ARM:  state_n = S_WAIT;
         S_WAIT: begin
            if (cop.cop_valid || tmo_hit)
               state_n = S_GAP;
         end
         S_GAP: begin
            if (gap_done) begin
               if (!enable)
                  state_n = S_IDLE;
               else if (pend_init)
                  state_n = S_INIT;
               else
                  state_n = S_ARM;
            end
         end
         default: state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= S_IDLE;
      else
         state <= state_n;
   end

   // A reinit landing in the INIT cycle itself is kept for the next round.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         pend_init <= 1'b1;
      else
         pend_init <= reinit | (pend_init & (state != S_INIT));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pcnt    <= '0;
         tmo_cnt <= '0;
      end else begin
         if (state == S_ARM)
            pcnt <= p_load;
         else if ((state == S_WAIT || state == S_GAP) && pcnt != '0)
            pcnt <= pcnt - PERIOD_W'(1);
         if (state == S_ARM)
            tmo_cnt <= '0;
         else if (state == S_WAIT)
            tmo_cnt <= tmo_cnt + TMO_W'(1);
      end
   end

`ifdef FUZZY_SEQ_TAG_EN
   logic [7:0] seq;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         seq <= '0;
      else if (state == S_ARM)
         seq <= seq + 8'd1;
   end

   assign wdata   = {seq, cop.cop_g};
   assign res_seq = res_avail ? head[15:8] : 8'd0;
`else
   assign wdata   = cop.cop_g;
   assign res_seq = 8'd0;
`endif

   assign full     = (cnt == CNT_W'(FIFO_DEPTH));
   assign empty    = (cnt == '0);
   assign push_req = (state == S_WAIT) && cop.cop_valid;
   assign do_pop   = res_pop && !empty;
   // A same-cycle pop frees the slot, so a full FIFO still accepts the push.
   assign do_push  = push_req && (!full || do_pop);
   assign drop     = push_req && full && !do_pop;

   always_ff @(posedge clk) begin
      if (do_push)
         mem[wr_ptr] <= wdata;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (do_push)
            wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop)
            rd_ptr <= rd_ptr + PTR_W'(1);
         unique case ({do_push, do_pop})
            2'b10:   cnt <= cnt + CNT_W'(1);
            2'b01:   cnt <= cnt - CNT_W'(1);
            default: cnt <= cnt;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf_err <= 1'b0;
         tmo_err <= 1'b0;
      end else if (clr_err) begin
         ovf_err <= 1'b0;
         tmo_err <= 1'b0;
      end else begin
         ovf_err <= ovf_err | drop;
         tmo_err <= tmo_err | tmo_hit;
      end
   end

   assign head          = mem[rd_ptr];
   assign res_avail     = !empty;
   assign res_data      = res_avail ? head[7:0] : 8'd0;
   assign fifo_cnt      = cnt;
   assign busy          = (state == S_ARM) || (state == S_WAIT);
   assign cop.cop_start = (state == S_ARM);
   assign cop.cop_init  = (state == S_INIT);

endmodule

// File: tb/tb_fuzzy_seq_ctrl.sv
// Directed bench for fuzzy_seq_ctrl with a simple coprocessor core model.
// Expected values are hand-derived from the cycle timing of the sequencer.
module tb_fuzzy_seq_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        enable;
   logic        reinit;
   logic [15:0] period;
   logic [7:0]  res_data;
   logic [7:0]  res_seq;
   logic        res_avail;
   logic        res_pop;
   logic [2:0]  fifo_cnt;
   logic        busy;
   logic        ovf_err;
   logic        tmo_err;
   logic        clr_err;

   fuzzy_seq_ctrl_if cif ();

   fuzzy_seq_ctrl #(
      .PERIOD_W   (16),
      .TMO_CYC    (15),
      .FIFO_DEPTH (4)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .enable    (enable),
      .reinit    (reinit),
      .period    (period),
      .cop       (cif),
      .res_data  (res_data),
      .res_seq   (res_seq),
      .res_avail (res_avail),
      .res_pop   (res_pop),
      .fifo_cnt  (fifo_cnt),
      .busy      (busy),
      .ovf_err   (ovf_err),
      .tmo_err   (tmo_err),
      .clr_err   (clr_err)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int last_start = 0;
   int n_start  = 0;
   int n_init   = 0;
   int gap;
   int saved;

   bit       model_on  = 1'b0;
   int       model_dly = 2;
   logic [7:0] model_g = 8'd0;

   // Core model: one-cycle done pulse model_dly cycles after start rise.
   initial begin
      int cd;
      cd = 0;
      cif.cop_valid = 1'b0;
      cif.cop_g     = 8'd0;
      forever begin
         @(posedge clk);
         #1;
         cif.cop_valid = 1'b0;
         if (cd > 0) begin
            cd--;
            if (cd == 0) begin
               cif.cop_valid = 1'b1;
               cif.cop_g     = model_g;
            end
         end
         if (cif.cop_start && model_on)
            cd = model_dly;
      end
   end

   // Rising-edge counters for init and start.
   initial begin
      logic ps, pi;
      ps = 1'b0;
      pi = 1'b0;
      forever begin
         @(negedge clk);
         if (cif.cop_start === 1'b1 && !ps) n_start++;
         if (cif.cop_init === 1'b1 && !pi) n_init++;
         ps = (cif.cop_start === 1'b1);
         pi = (cif.cop_init === 1'b1);
      end
   end

   function automatic int tagv(input int n);
`ifdef FUZZY_SEQ_TAG_EN
      return n;
`else
      return 0;
`endif
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic wait_start(output int g);
      int n;
      n = 0;
      do begin
         step();
         n++;
      end while (cif.cop_start !== 1'b1 && n < 200);
      chk("start_seen", 32'(cif.cop_start), 32'd1);
      g = cyc - last_start;
      last_start = cyc;
   endtask

   initial begin
      rst_n   = 1'b0;
      enable  = 1'b0;
      reinit  = 1'b0;
      period  = 16'd20;
      res_pop = 1'b0;
      clr_err = 1'b0;
      steps(2);
      chk("rst_busy",  32'(busy), 32'd0);
      chk("rst_start", 32'(cif.cop_start), 32'd0);
      chk("rst_init",  32'(cif.cop_init), 32'd0);
      chk("rst_avail", 32'(res_avail), 32'd0);
      chk("rst_cnt",   32'(fifo_cnt), 32'd0);
      chk("rst_errs",  32'({ovf_err, tmo_err}), 32'd0);
      chk("rst_data",  32'(res_data), 32'd0);
      rst_n = 1'b1;
      step();

      // 1: init once, then starts every 20 cycles, FIFO fills with G=77
      model_on  = 1'b1;
      model_dly = 2;
      model_g   = 8'd77;
      enable    = 1'b1;
      step();
      chk("t1_init_hi", 32'(cif.cop_init), 32'd1);
      chk("t1_init_nostart", 32'(cif.cop_start), 32'd0);
      last_start = cyc;
      wait_start(gap);
      chk("t1_init_to_start", 32'(gap), 32'd1);
      chk("t1_start_noinit", 32'(cif.cop_init), 32'd0);
      chk("t1_busy", 32'(busy), 32'd1);
      for (int i = 0; i < 3; i++) begin
         wait_start(gap);
         chk("t1_spacing", 32'(gap), 32'd20);
      end
      steps(3);
      chk("t1_cnt", 32'(fifo_cnt), 32'd4);
      chk("t1_data", 32'(res_data), 32'd77);
      chk("t1_tag", 32'(res_seq), 32'(tagv(1)));
      chk("t1_ninit", 32'(n_init), 32'd1);
      chk("t1_ovf0", 32'(ovf_err), 32'd0);

      // 2: fifth result dropped
      wait_start(gap);
      chk("t2_spacing", 32'(gap), 32'd20);
      steps(3);
      chk("t2_ovf", 32'(ovf_err), 32'd1);
      chk("t2_cnt", 32'(fifo_cnt), 32'd4);
      chk("t2_tag", 32'(res_seq), 32'(tagv(1)));
      clr_err = 1'b1;
      step();
      clr_err = 1'b0;
      chk("t2_clr", 32'(ovf_err), 32'd0);

      // 5: pop and push in the same cycle while full
      model_g = 8'd88;
      wait_start(gap);
      chk("t5_spacing", 32'(gap), 32'd20);
      steps(2);
      res_pop = 1'b1;
      step();
      res_pop = 1'b0;
      chk("t5_cnt", 32'(fifo_cnt), 32'd4);
      chk("t5_ovf", 32'(ovf_err), 32'd0);
      chk("t5_tag", 32'(res_seq), 32'(tagv(2)));
      res_pop = 1'b1;
      steps(3);
      res_pop = 1'b0;
      chk("t5_tail_data", 32'(res_data), 32'd88);
      chk("t5_tail_tag", 32'(res_seq), 32'(tagv(6)));
      chk("t5_tail_cnt", 32'(fifo_cnt), 32'd1);
      res_pop = 1'b1;
      step();
      res_pop = 1'b0;
      chk("t5_empty_cnt", 32'(fifo_cnt), 32'd0);
      chk("t5_empty_avail", 32'(res_avail), 32'd0);
      model_on = 1'b0;

      // 3: core never answers
      wait_start(gap);
      chk("t3_spacing", 32'(gap), 32'd20);
      steps(15);
      chk("t3_tmo_early", 32'(tmo_err), 32'd0);
      chk("t3_busy_wait", 32'(busy), 32'd1);
      step();
      chk("t3_tmo", 32'(tmo_err), 32'd1);
      chk("t3_busy_gap", 32'(busy), 32'd0);
      chk("t3_nopush", 32'(fifo_cnt), 32'd0);
      model_on = 1'b1;
      model_g  = 8'd50;
      clr_err  = 1'b1;
      step();
      clr_err  = 1'b0;
      chk("t3_clr", 32'(tmo_err), 32'd0);
      wait_start(gap);
      chk("t3_next_spacing", 32'(gap), 32'd20);

      // 4: reinit during WAIT
      step();
      reinit = 1'b1;
      step();
      reinit = 1'b0;
      step();
      chk("t4_cnt", 32'(fifo_cnt), 32'd1);
      chk("t4_data", 32'(res_data), 32'd50);
      chk("t4_tag", 32'(res_seq), 32'(tagv(8)));
      period    = 16'd0;
      model_dly = 1;
      steps(17);
      chk("t4_init_hi", 32'(cif.cop_init), 32'd1);
      chk("t4_init_nostart", 32'(cif.cop_start), 32'd0);
      wait_start(gap);
      chk("t4_spacing", 32'(gap), 32'd21);
      chk("t4_ninit", 32'(n_init), 32'd2);

      // 6: minimum spacing, then enable dropped mid-evaluation
      wait_start(gap);
      chk("t6_min_spacing", 32'(gap), 32'd3);
      step();
      enable = 1'b0;
      steps(2);
      chk("t6_idle_busy", 32'(busy), 32'd0);
      chk("t6_cnt", 32'(fifo_cnt), 32'd3);
      saved = n_start;
      steps(10);
      chk("t6_no_start", 32'(n_start), 32'(saved));
      chk("t6_head", 32'(res_data), 32'd50);

      // 6b: reset in WAIT, late done ignored
      model_dly = 3;
      enable    = 1'b1;
      step();
      chk("t6_arm", 32'(cif.cop_start), 32'd1);
      step();
      chk("t6_wait_busy", 32'(busy), 32'd1);
      rst_n  = 1'b0;
      enable = 1'b0;
      #1;
      chk("t6_rst_busy", 32'(busy), 32'd0);
      chk("t6_rst_cnt", 32'(fifo_cnt), 32'd0);
      chk("t6_rst_avail", 32'(res_avail), 32'd0);
      chk("t6_rst_start", 32'(cif.cop_start), 32'd0);
      step();
      rst_n = 1'b1;
      steps(2);
      chk("t6_late_cnt", 32'(fifo_cnt), 32'd0);
      chk("t6_late_err", 32'({ovf_err, tmo_err}), 32'd0);
      chk("t6_late_busy", 32'(busy), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/fuzzy_seq_ctrl.md
Name: fuzzy_seq_ctrl

Overview:
Periodic sequencer for the fuzzy-logic coprocessor core.
- Generates the coprocessor's edge-triggered init and start levels at a programmable sample period.
- Supervises completion with a timeout.
- Buffers results in a small FIFO drained by the MMIO side.
- Sits between the shadow-register/MMIO layer and the coprocessor core; replaces software-timed start toggling.

Parameters:
PERIOD_W, 16, width of the sample-period counter
TMO_CYC, 15, cycles allowed from start rise to cop_valid before timeout (TMO_CYC >= 3)
FIFO_DEPTH, 4, result FIFO entries; power of two, >= 2

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
enable  in  1  level; 1 = run periodic sampling, 0 = stop after current evaluation
reinit  in  1  1-cycle pulse; request estimator re-init before next start
period  in  PERIOD_W  cycles between successive start rises; 0 and 1 treated as 2
cop_start  out  1  to core start (level, rising edge = go)
cop_init  out  1  to core init (level, rising edge = re-init)
cop_valid  in  1  core 1-cycle DONE pulse
cop_g  in  8  core G_out, valid when cop_valid=1
res_data  out  8  FIFO head result
res_seq  out  8  FIFO head sequence tag (see Optional Feature)
res_avail  out  1  FIFO not empty
res_pop  in  1  pop FIFO head; ignored when empty
fifo_cnt  out  $clog2(FIFO_DEPTH)+1  occupancy
busy  out  1  evaluation in flight (ARM or WAIT)
ovf_err  out  1  sticky: result dropped because FIFO full
tmo_err  out  1  sticky: cop_valid not seen within TMO_CYC
clr_err  in  1  clears ovf_err and tmo_err

Behaviour:
- Reset: all outputs 0, FIFO empty, state IDLE, period counter 0, pending-init flag set.
- Init is mandatory after reset.
- States:
  - IDLE: if enable=1: go to INIT when pending-init=1, otherwise to ARM.
  - INIT: cop_init=1 for exactly 1 cycle; clear pending-init; go to ARM.
  - ARM: cop_start=1 for exactly 1 cycle; load period counter with max(period,2)-1; clear timeout counter; go to WAIT.
  - WAIT: cop_start=0. Period counter decrements each cycle, saturating at 0.
    - On cop_valid: push {seq, cop_g} and go to GAP.
    - If the timeout counter reaches TMO_CYC with no cop_valid: set tmo_err, no push, go to GAP.
  - GAP: period counter keeps decrementing. When it is 0:
    - go to IDLE if enable=0;
    - go to INIT if pending-init=1;
    - otherwise go to ARM.
- Start-rise spacing = max(period,2) cycles, as long as evaluation + init fit. Otherwise, the next start is issued on the first cycle the state machine permits.
- cop_start and cop_init are never high in the same cycle. Each returns low for >= 1 cycle between rises.
- reinit in any state sets pending-init. It takes effect at the next INIT opportunity and never aborts an evaluation in flight.
- cop_valid outside WAIT is ignored: no push, no error.
- FIFO is synchronous with combinational head outputs. res_data/res_seq are valid whenever res_avail=1.
- Push and pop in the same cycle:
  - FIFO full: pop and push both succeed; no overflow.
  - FIFO empty: only the push takes effect.
- Push while full without pop: drop the new result, set ovf_err.
- clr_err has priority over a same-cycle error set (clear wins). Errors stay set until clr_err.
- seq: 8-bit counter incremented on every ARM entry, wraps 255->0. Reset value 0, so the first sample is tagged 1.
- busy=1 in ARM and WAIT.
- Asynchronous reset mid-evaluation: returns to the reset state immediately. A late cop_valid after reset is ignored (state is IDLE).

Optional Feature:
FUZZY_SEQ_TAG_EN
- Defined: res_seq carries the stored seq tag of the FIFO head; FIFO entries are 16 bits.
- Undefined: res_seq is tied to 0 and FIFO entries are 8 bits. Everything else is identical.

Test Plan:
1. After reset, enable=1, period=20, core model returns valid 2 cycles after start rise, G=77 → cop_init pulses once, then cop_start rises every 20 cycles. FIFO fills to 4 with res_data=77 and tags 1..4.
2. With no pops, continue to 5th result → ovf_err=1, fifo_cnt stays 4, head still tag 1. Assert clr_err → ovf_err=0.
3. Core model never asserts valid, TMO_CYC=15 → tmo_err set 15 cycles after start rise. No push. Next start still at period spacing.
4. reinit pulsed during WAIT → current result (G=50) pushed normally. Next cycle sequence is cop_init pulse then cop_start, spacing >= 1 low cycle.
5. FIFO full, res_pop and result push in same cycle → fifo_cnt stays 4; head advances to next tag; new result at tail; no ovf_err.
6. period=0, enable dropped during WAIT → start spacing 2 cycles minimum. Current result pushed, state returns to IDLE, no further cop_start. rst_n asserted mid-WAIT → all outputs 0.
